// File: rtl/dpram_be_init.sv
// rtl/dpram_be_init.sv - single-clock true dual-port RAM with byte enables and hardware clear
//
// Purpose:
//    Two independent read/write ports on one array, all logic on posedge clock.
//    Per-byte write enables are honoured on both ports. Same-port read-during-write
//    returns old or merged data (RDW_MODE). A cross-port read of a word being written
//    returns the old word. When both ports write one address, port A owns every lane
//    it enables and port B fills only the lanes A leaves alone. An overlapping
//    write/write is flagged on collision one cycle later. After reset, or on clear_req
//    in IDLE, a clear sequencer writes CLEAR_VAL to every word, one word per cycle.
//    While it runs, busy is high, port writes are dropped and q_a/q_b/collision are 0.
//
// Parameters:
//    ADDR_W    address width, depth = 2**ADDR_W
//    DATA_W    word width, multiple of 8, NB = DATA_W/8 byte lanes
//    RDW_MODE  same-port read-during-write: 0 = old word, 1 = merged word
//    CLEAR_VAL value written to every word by the clear sequencer
//
// Ports:
//    clock, reset        single clock, synchronous active-high reset
//    clear_req           pulse, start a clear sequence (only accepted in IDLE)
//    busy                high while the clear sequencer owns the array
//    address_x, data_x   port x address / write data (x = a, b)
//    wren_x, byteena_x   port x write enable / byte-lane enables
//    q_x                 port x read data
//    collision           one-cycle pulse after a same-address overlapping write/write
//
// Build option:
//    DPRAM_OUTREG_EN     when defined, adds an output register on q_a/q_b (read latency 2);
//                        collision latency is unchanged

module dpram_be_init #(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 8,
   parameter int                RDW_MODE  = 0,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear_req,
   output logic                   busy,
   input  logic [ADDR_W-1:0]      address_a,
   input  logic [DATA_W-1:0]      data_a,
   input  logic                   wren_a,
   input  logic [DATA_W/8-1:0]    byteena_a,
   output logic [DATA_W-1:0]      q_a,
   input  logic [ADDR_W-1:0]      address_b,
   input  logic [DATA_W-1:0]      data_b,
   input  logic                   wren_b,
   input  logic [DATA_W/8-1:0]    byteena_b,
   output logic [DATA_W-1:0]      q_b,
   output logic                   collision
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              busy_q;
   logic              clr_we;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [NB-1:0]     lane_we_a, lane_we_b, lane_we_b_eff;
   logic              addr_eq;
   logic [DATA_W-1:0] old_a, old_b, merged_a, merged_b;
   logic [DATA_W-1:0] q_a_d, q_a_q, q_b_d, q_b_q;
   logic              collision_d, collision_q;

   // ---------------------------------------------------------------------
   // Clear sequencer
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we = 1'b1;
            if (cnt_q == LAST_WORD) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (clear_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // busy is registered from the next state so it falls the cycle after the last clear write
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == ST_CLEAR);
      end
   end

   assign busy = busy_q;

   // ---------------------------------------------------------------------
   // Port write lanes and read data selection
   // ---------------------------------------------------------------------
   always_comb begin
      addr_eq       = (address_a == address_b);
      lane_we_a     = '0;
      lane_we_b     = '0;
      lane_we_b_eff = '0;
      old_a         = mem[address_a];
      old_b         = mem[address_b];
      merged_a      = old_a;
      merged_b      = old_b;
      for (int i = 0; i < NB; i++) begin
         lane_we_a[i] = ~busy_q & wren_a & byteena_a[i];
         lane_we_b[i] = ~busy_q & wren_b & byteena_b[i];
         // Port A owns a lane both ports enable at the same address
         lane_we_b_eff[i] = lane_we_b[i] & ~(lane_we_a[i] & addr_eq);
         if (lane_we_a[i]) merged_a[8*i +: 8] = data_a[8*i +: 8];
         if (lane_we_b[i]) merged_b[8*i +: 8] = data_b[8*i +: 8];
      end

      // Merged word only reflects the reading port's own write; other-port data is old
      if (busy_q) begin
         q_a_d = '0;
         q_b_d = '0;
      end else if (RDW_MODE != 0) begin
         q_a_d = merged_a;
         q_b_d = merged_b;
      end else begin
         q_a_d = old_a;
         q_b_d = old_b;
      end

      collision_d = ~busy_q & wren_a & wren_b & addr_eq & (|(byteena_a & byteena_b));
   end

   // ---------------------------------------------------------------------
   // Array: clear sequencer has exclusive access while busy
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (clr_we) begin
            mem[cnt_q[ADDR_W-1:0]] <= CLEAR_VAL;
         end else begin
            for (int i = 0; i < NB; i++) begin
               if (lane_we_a[i])     mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
               if (lane_we_b_eff[i]) mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read and collision registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         q_a_q       <= '0;
         q_b_q       <= '0;
         collision_q <= 1'b0;
      end else begin
         q_a_q       <= q_a_d;
         q_b_q       <= q_b_d;
         collision_q <= collision_d;
      end
   end

   assign collision = collision_q;

`ifdef DPRAM_OUTREG_EN
   logic [DATA_W-1:0] q_a_o_d, q_a_o_q, q_b_o_d, q_b_o_q;

   always_comb begin
      q_a_o_d = busy_q ? '0 : q_a_q;
      q_b_o_d = busy_q ? '0 : q_b_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q_a_o_q <= '0;
         q_b_o_q <= '0;
      end else begin
         q_a_o_q <= q_a_o_d;
         q_b_o_q <= q_b_o_d;
      end
   end

   assign q_a = q_a_o_q;
   assign q_b = q_b_o_q;
`else
   assign q_a = q_a_q;
   assign q_b = q_b_q;
`endif

endmodule

// File: tb/tb_dpram_be_init.sv
// tb/tb_dpram_be_init.sv - randomized self-checking bench for dpram_be_init against a word-level model

module tb_dpram_be_init;

   logic        clk = 1'b0;
   logic        rst;
   logic        creq;
   logic [3:0]  addr_a, addr_b;
   logic [15:0] dat_a, dat_b;
   logic        we_a, we_b;
   logic [1:0]  be_a, be_b;

   logic [7:0]  q0a, q0b;
   logic [15:0] q1a, q1b;
   logic        busy0, busy1, col0, col1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Instance 0: 8-bit words, old-data read-during-write
   dpram_be_init #(.ADDR_W(4), .DATA_W(8), .RDW_MODE(0), .CLEAR_VAL(8'hA5)) u0 (
      .clock(clk), .reset(rst), .clear_req(creq), .busy(busy0),
      .address_a(addr_a), .data_a(dat_a[7:0]), .wren_a(we_a), .byteena_a(be_a[0:0]), .q_a(q0a),
      .address_b(addr_b), .data_b(dat_b[7:0]), .wren_b(we_b), .byteena_b(be_b[0:0]), .q_b(q0b),
      .collision(col0)
   );

   // Instance 1: 16-bit words, merged read-during-write
   dpram_be_init #(.ADDR_W(4), .DATA_W(16), .RDW_MODE(1), .CLEAR_VAL(16'hC3A5)) u1 (
      .clock(clk), .reset(rst), .clear_req(creq), .busy(busy1),
      .address_a(addr_a), .data_a(dat_a), .wren_a(we_a), .byteena_a(be_a), .q_a(q1a),
      .address_b(addr_b), .data_b(dat_b), .wren_b(we_b), .byteena_b(be_b), .q_b(q1b),
      .collision(col1)
   );

   // Reference model: whole words, remaining-clear count, expected outputs
   logic [15:0] mm [2][16];
   bit          mbusy [2];
   int          mleft [2];
   logic [15:0] eq_a [2], eq_b [2], eo_a [2], eo_b [2];
   bit          ecol [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] overlay(input logic [15:0] w, input logic [15:0] d, input logic [1:0] m);
      logic [15:0] r;
      r = w;
      for (int l = 0; l < 2; l++) if (m[l]) r[8*l +: 8] = d[8*l +: 8];
      return r;
   endfunction

   // Predict what the coming clock edge does to each instance
   task automatic predict();
      for (int d = 0; d < 2; d++) begin
         logic [1:0]  lmask, ma, mb;
         logic [15:0] old_a, old_b;
         lmask = (d == 0) ? 2'b01 : 2'b11;
         if (rst) begin
            mbusy[d] = 1; mleft[d] = 16;
            eq_a[d] = 0; eq_b[d] = 0; eo_a[d] = 0; eo_b[d] = 0; ecol[d] = 0;
         end else if (mbusy[d]) begin
            mm[d][16 - mleft[d]] = (d == 0) ? 16'h00A5 : 16'hC3A5;
            mleft[d]--;
            if (mleft[d] == 0) mbusy[d] = 0;
            eq_a[d] = 0; eq_b[d] = 0; eo_a[d] = 0; eo_b[d] = 0; ecol[d] = 0;
         end else begin
            ma = we_a ? (be_a & lmask) : 2'b00;
            mb = we_b ? (be_b & lmask) : 2'b00;
            old_a = mm[d][addr_a];
            old_b = mm[d][addr_b];
            eo_a[d] = eq_a[d];
            eo_b[d] = eq_b[d];
            eq_a[d] = (d == 1) ? overlay(old_a, dat_a, ma) : old_a;
            eq_b[d] = (d == 1) ? overlay(old_b, dat_b, mb) : old_b;
            ecol[d] = (addr_a == addr_b) && ((ma & mb) != 2'b00);
            // B then A, so A's lanes override wherever both write one word
            mm[d][addr_b] = overlay(mm[d][addr_b], dat_b, mb);
            mm[d][addr_a] = overlay(mm[d][addr_a], dat_a, ma);
            if (creq) begin mbusy[d] = 1; mleft[d] = 16; end
         end
      end
   endtask

   task automatic step();
      logic [15:0] xa0, xb0, xa1, xb1;
      predict();
      @(posedge clk);
      #1;
`ifdef DPRAM_OUTREG_EN
      xa0 = eo_a[0]; xb0 = eo_b[0]; xa1 = eo_a[1]; xb1 = eo_b[1];
`else
      xa0 = eq_a[0]; xb0 = eq_b[0]; xa1 = eq_a[1]; xb1 = eq_b[1];
`endif
      check("busy0", busy0, mbusy[0]);
      check("busy1", busy1, mbusy[1]);
      check("col0", col0, ecol[0]);
      check("col1", col1, ecol[1]);
      check("q0a", q0a, xa0[7:0]);
      check("q0b", q0b, xb0[7:0]);
      check("q1a", q1a, xa1);
      check("q1b", q1b, xb1);
   endtask

   task automatic idle_inputs();
      creq = 0; we_a = 0; we_b = 0; be_a = 2'b11; be_b = 2'b11;
      dat_a = 0; dat_b = 0;
   endtask

   task automatic rand_inputs(input bit allow_ctrl);
      addr_a = 4'($urandom_range(0, 15));
      addr_b = ($urandom_range(0, 1) == 0) ? addr_a : 4'($urandom_range(0, 15));
      dat_a  = 16'($urandom);
      dat_b  = 16'($urandom);
      we_a   = 1'($urandom_range(0, 1));
      we_b   = 1'($urandom_range(0, 1));
      be_a   = 2'($urandom_range(0, 3));
      be_b   = 2'($urandom_range(0, 3));
      creq   = allow_ctrl && ($urandom_range(0, 99) == 0);
      rst    = allow_ctrl && ($urandom_range(0, 299) == 0);
   endtask

   initial begin
      int busy_cycles;
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 16; a++) mm[d][a] = 16'h0;
      idle_inputs();
      addr_a = 0; addr_b = 0;
      rst = 1;

      // Reset state
      step();
      step();
      check("reset_busy", busy0, 1'b1);
      check("reset_q", q1a, 16'h0);
      rst = 0;

      // Clear after reset: busy for exactly 16 cycles
      repeat (15) step();
      check("busy_at_15", busy0, 1'b1);
      step();
      check("busy_at_16", busy0, 1'b0);
      check("busy1_at_16", busy1, 1'b0);

      // Read every word on both ports
      for (int a = 0; a < 16; a++) begin
         addr_a = 4'(a); addr_b = 4'(15 - a);
         step();
      end
      addr_a = 4'd9; addr_b = 4'd9;
      step(); step();
      check("clear_val0", q0a, 8'hA5);
      check("clear_val1", q1b, 16'hC3A5);

      // Byte-enable merge at address 3
      addr_a = 4'd3; we_a = 1; dat_a = 16'h1234; be_a = 2'b11; step();
      dat_a = 16'hABCD; be_a = 2'b10; step();
      we_a = 0; step(); step();
      check("be_merge1", q1a, 16'hAB34);
      check("be_merge0", q0a, 8'h34);

      // Same-port read-during-write at address 5
      addr_a = 4'd5; we_a = 1; be_a = 2'b11; dat_a = 16'h0011; step();
      dat_a = 16'h0022; step();
`ifdef DPRAM_OUTREG_EN
      we_a = 0; addr_a = 4'd9; step();
`endif
      check("rdw_old", q0a, 8'h11);
      check("rdw_new", q1a, 16'h0022);
      we_a = 0;

      // Write/write collision at address 7
      addr_a = 4'd7; addr_b = 4'd7; we_a = 1; we_b = 1; be_a = 2'b11; be_b = 2'b11;
      dat_a = 16'h000F; dat_b = 16'h00F0; step();
      check("col_set0", col0, 1'b1);
      check("col_set1", col1, 1'b1);
      we_a = 0; we_b = 0; step();
      check("col_clr", col0, 1'b0);
      step();
      check("col_word0", q0a, 8'h0F);
      check("col_word1", q1b, 16'h000F);

      // Disjoint lanes at one address: no collision
      we_a = 1; we_b = 1; be_a = 2'b01; be_b = 2'b10; step();
      check("no_col", col1, 1'b0);
      we_a = 0; we_b = 0;

      // clear_req, then reset 3 cycles into the clear; writes during busy dropped
      creq = 1; step();
      creq = 0;
      check("creq_busy", busy1, 1'b1);
      repeat (3) begin rand_inputs(0); step(); end
      rst = 1; step();
      rst = 0;
      busy_cycles = 0;
      for (int c = 0; c < 40; c++) begin
         if (busy0) busy_cycles++;
         rand_inputs(0);
         step();
      end
      check("busy_len", busy_cycles, 16);
      idle_inputs();
      for (int a = 0; a < 16; a++) begin
         addr_a = 4'(a); addr_b = 4'(a ^ 4'hF);
         step();
      end

      // Port B read latency at address 2
      addr_a = 4'd2; we_a = 1; be_a = 2'b11; dat_a = 16'h005A; addr_b = 4'd0; step();
      we_a = 0; addr_a = 4'd0; addr_b = 4'd2; step(); step();
      check("lat_b", q0b, 8'h5A);

      // Random traffic with occasional clear requests and resets
      for (int c = 0; c < 3000; c++) begin
         rand_inputs(1);
         step();
      end
      rst = 0;
      idle_inputs();
      repeat (20) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
